// File: rtl/first_pkg.sv
// rtl/first_pkg.sv - shared defaults, packer state encoding and pair decode for first_decoder
package first_pkg;

   localparam int PAIRS_DEF      = 4;
   localparam int FIFO_DEPTH_DEF = 2;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } pack_state_e;

   // Inverts the encoder: out2 = ~in2, out1 = in1 ^ in2. Result is {in1, in2}.
   function automatic logic [1:0] decode_pair(input logic out1, input logic out2);
      logic in2;
      in2 = ~out2;
      return {out1 ^ in2, in2};
   endfunction

endpackage

// File: rtl/first_decoder_if.sv
// rtl/first_decoder_if.sv - pair input and packed word output handshake bundle
// slave : s_valid/s_out1/s_out2/s_last/m_ready in, s_ready/m_valid/m_data/m_len out
// master: the opposite directions, for the producer/consumer side
interface first_decoder_if
   import first_pkg::*;
#(
   parameter int PAIRS = PAIRS_DEF
);
   localparam int LW = $clog2(PAIRS) + 1;

   logic             s_valid;
   logic             s_ready;
   logic             s_out1;
   logic             s_out2;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [2*PAIRS-1:0] m_data;
   logic [LW-1:0]    m_len;

   modport slave (
      input  s_valid, s_out1, s_out2, s_last, m_ready,
      output s_ready, m_valid, m_data, m_len
   );

   modport master (
      output s_valid, s_out1, s_out2, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_len
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read and push-while-full-on-pop
// clk/rst : clock, synchronous active-high reset (empties the FIFO)
// push/wdata in, pop in, rdata = head entry, full/empty status out
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/first_decoder.sv
// rtl/first_decoder.sv - decodes encoded pairs and packs them into words of up to PAIRS pairs
// clk/rst : clock, synchronous active-high reset
// bus     : slave side of first_decoder_if (pair input stream, packed word output stream)
module first_decoder
   import first_pkg::*;
#(
   parameter int PAIRS      = PAIRS_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   first_decoder_if.slave bus
);
   localparam int LW = $clog2(PAIRS) + 1;
   localparam int DW = 2 * PAIRS;
   localparam int WW = DW + LW;

   localparam logic [0:0] ST_ACCUM = ACCUM;
   localparam logic [0:0] ST_HOLD  = HOLD;

   logic [0:0]    state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [WW-1:0] hold_q, hold_d;

   logic [DW-1:0] acc_next;
   logic [LW-1:0] cnt_next;
   logic          accept;
   logic          word_done;
   logic          push;
   logic [WW-1:0] push_word;
   logic [WW-1:0] fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          can_push;

   assign pop         = ~fifo_empty & bus.m_ready;
   assign can_push    = ~fifo_full | pop;
   assign bus.s_ready = (state_q == ST_ACCUM);
   assign accept      = bus.s_valid & bus.s_ready;

   always_comb begin
      acc_next = acc_q;
      acc_next[2*cnt_q +: 2] = decode_pair(bus.s_out1, bus.s_out2);
      cnt_next  = cnt_q + LW'(1);
      word_done = accept & (bus.s_last | (cnt_q == LW'(PAIRS - 1)));

      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      hold_d    = hold_q;
      push      = 1'b0;
      push_word = {cnt_next, acc_next};

      if (state_q == ST_HOLD) begin
         push_word = hold_q;
         if (can_push) begin
            push    = 1'b1;
            state_d = ST_ACCUM;
         end
      end else if (accept) begin
         if (word_done) begin
            // The partial word restarts at k=0 whether or not the finished word stalls.
            cnt_d = '0;
            acc_d = '0;
            if (can_push) begin
               push = 1'b1;
            end else begin
               hold_d  = {cnt_next, acc_next};
               state_d = ST_HOLD;
            end
         end else begin
            cnt_d = cnt_next;
            acc_d = acc_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         hold_q  <= hold_d;
      end
   end

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_word),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Word fields read as zero whenever no word is on offer.
   assign bus.m_valid = ~fifo_empty;
   assign bus.m_data  = fifo_empty ? '0 : fifo_rdata[DW-1:0];
   assign bus.m_len   = fifo_empty ? '0 : fifo_rdata[WW-1:DW];

endmodule

// File: tb/tb_first_decoder.sv
// tb/tb_first_decoder.sv - self-checking bench for first_decoder against a word-queue model
module tb_first_decoder;
   localparam int PAIRS = 4;
   localparam int DEPTH = 2;

   typedef struct {
      int data;
      int len;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   first_decoder_if #(.PAIRS(PAIRS)) ifc ();

   first_decoder #(
      .PAIRS      (PAIRS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   word_t exp_q[$];
   int    fr_data = 0;
   int    fr_n = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Value of {in1,in2} for an encoded pair, straight from the encoder equations.
   function automatic int pair_val(input bit o1, input bit o2);
      int in2, in1;
      in2 = 1 - o2;
      in1 = (o1 + in2) % 2;
      return in1 * 2 + in2;
   endfunction

   // Words completed but not yet taken: the FIFO holds up to DEPTH, one more may wait in HOLD.
   task automatic compare();
      check("s_ready", ifc.s_ready, (exp_q.size() <= DEPTH) ? 1 : 0);
      check("m_valid", ifc.m_valid, (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
         check("m_data", ifc.m_data, exp_q[0].data);
         check("m_len", ifc.m_len, exp_q[0].len);
      end
   endtask

   task automatic cycle(input bit v, input bit o1, input bit o2, input bit l,
                        input bit mr, input bit r);
      bit ready_m;
      word_t w;
      @(negedge clk);
      compare();
      rst         = r;
      ifc.s_valid = v;
      ifc.s_out1  = o1;
      ifc.s_out2  = o2;
      ifc.s_last  = l;
      ifc.m_ready = mr;
      #1;
      if (r) begin
         exp_q.delete();
         fr_data = 0;
         fr_n    = 0;
      end else begin
         ready_m = (exp_q.size() <= DEPTH);
         if (exp_q.size() > 0 && mr) void'(exp_q.pop_front());
         if (v && ready_m) begin
            fr_data += pair_val(o1, o2) << (2 * fr_n);
            fr_n++;
            if (l || fr_n == PAIRS) begin
               w.data = fr_data;
               w.len  = fr_n;
               exp_q.push_back(w);
               fr_data = 0;
               fr_n    = 0;
            end
         end
      end
   endtask

   task automatic idle(input bit mr);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, mr, 1'b0);
   endtask

   task automatic peek_word(input string name, input int data, input int len);
      @(posedge clk);
      #1;
      check({name, "_valid"}, ifc.m_valid, 1);
      check({name, "_data"}, ifc.m_data, data);
      check({name, "_len"}, ifc.m_len, len);
   endtask

   task automatic peek_ready(input string name, input int exp);
      @(posedge clk);
      #1;
      check(name, ifc.s_ready, exp);
   endtask

   task automatic send_word_36(input bit mr);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, mr, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, mr, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, mr, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, mr, 1'b0);
   endtask

   task automatic rand_pair(input bit mr);
      cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, mr, 1'b0);
   endtask

   initial begin
      ifc.s_valid = 1'b0;
      ifc.s_out1  = 1'b0;
      ifc.s_out2  = 1'b0;
      ifc.s_last  = 1'b0;
      ifc.m_ready = 1'b0;
      rst         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_valid", ifc.m_valid, 0);
      check("rst_m_data", ifc.m_data, 0);
      check("rst_m_len", ifc.m_len, 0);
      check("rst_s_ready", ifc.s_ready, 1);
      rst = 1'b0;

      // Model pins against hand-computed pair values.
      check("model_pair_11", pair_val(1'b1, 1'b1), 2);
      check("model_pair_00", pair_val(1'b0, 1'b0), 3);

      // Full word, valid on the cycle after the 4th pair.
      send_word_36(1'b1);
      peek_word("full", 'h36, 4);
      idle(1'b1);

      // Short frame, then a one-pair frame that must start at k=0.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      peek_word("short", 'h0F, 2);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      peek_word("single", 'h02, 1);
      idle(1'b1);

      // s_last on the PAIRS-th pair yields exactly one word.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      peek_word("last4", 'h36, 4);
      idle(1'b1);
      idle(1'b1);

      // Backpressure: two words buffered, third held.
      for (int i = 0; i < 3 * PAIRS; i++) rand_pair(1'b0);
      peek_ready("bp_hold_s_ready", 0);
      idle(1'b1);
      peek_ready("bp_release_s_ready", 1);
      repeat (4) idle(1'b1);

      // Full FIFO popped in the cycle the next word completes: no HOLD.
      for (int i = 0; i < 2 * PAIRS; i++) rand_pair(1'b0);
      for (int i = 0; i < PAIRS - 1; i++) rand_pair(1'b0);
      rand_pair(1'b1);
      peek_ready("full_pop_s_ready", 1);
      repeat (4) idle(1'b1);

      // Reset mid-word discards the partial pairs.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      send_word_36(1'b1);
      peek_word("post_rst", 'h36, 4);
      idle(1'b1);
      @(posedge clk);
      #1;
      check("post_rst_empty", ifc.m_valid, 0);

      // Random traffic with random backpressure and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
               1'($urandom_range(5) == 0), 1'($urandom_range(2) != 0),
               1'($urandom_range(149) == 0));
      end
      repeat (6) idle(1'b1);
      @(negedge clk);
      compare();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
